// File: rtl/m_fetch_unit_if.sv
// Instruction-memory channel between the fetch stage (master) and imem (slave):
// req/gnt request handshake plus rvalid/rdata response for a single outstanding read.
interface m_fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/m_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one outstanding imem read at a time and
// holds the returned instruction in a one-entry buffer presented to the IF/ID register.
module m_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           stallF,
    input  logic           pcsrcD,
    input  logic [31:0]    pcbranchD,
    m_fetch_unit_if.master imem,
    output logic [31:0]    instrF,
    output logic [31:0]    pcplus4F,
    output logic [31:0]    pcF,
    output logic           instr_validF
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_DROP
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_inc;
    logic [31:0] redirect_pc;
    logic [31:0] instr_q;
    logic        buf_free;
    logic        req;
    logic        issue;
    logic        capture;

    assign redirect_pc = pcbranchD & ~32'h3;
    assign pc_inc      = pc + 32'd4;
    assign buf_free    = !instr_validF || !stallF;
    assign issue       = req && imem.gnt;
    // Data is kept only for a live request; a same-cycle redirect makes it stale.
    assign capture     = (state == S_WAIT) && imem.rvalid && !pcsrcD;

    assign imem.req  = req;
    assign imem.addr = pc;
    assign instrF    = instr_validF ? instr_q : NOP_INSTR;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        req        = 1'b0;
        unique case (state)
            S_FETCH: begin
                req = buf_free && !reset;
                if (issue) begin
                    state_next = pcsrcD ? S_DROP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem.rvalid) begin
                    state_next = S_FETCH;
                end else if (pcsrcD) begin
                    state_next = S_DROP;
                end
            end
            S_DROP: begin
                if (imem.rvalid) begin
                    state_next = S_FETCH;
                end
            end
            default: state_next = S_FETCH;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_FETCH;
            pc           <= RESET_PC;
            instr_validF <= 1'b0;
            instr_q      <= NOP_INSTR;
            pcF          <= 32'h0;
            pcplus4F     <= 32'h0;
        end else begin
            state <= state_next;

            if (pcsrcD) begin
                pc <= redirect_pc;
            end else if (capture) begin
                pc <= pc_inc;
            end

            // Redirect flush outranks capture, which outranks consume.
            if (pcsrcD) begin
                instr_validF <= 1'b0;
            end else if (capture) begin
                instr_validF <= 1'b1;
                instr_q      <= imem.rdata;
                pcF          <= pc;
                pcplus4F     <= pc_inc;
            end else if (!stallF) begin
                instr_validF <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_m_fetch_unit.sv
// Bench for m_fetch_unit: directed scenarios then random traffic, checked every cycle against
// a transaction-level model (queue of outstanding reads, instruction buffer, architectural PC).
module tb_m_fetch_unit;

    localparam logic [31:0] K     = 32'hA5A5_0000;
    localparam logic [31:0] HI_PC = 32'hFFFF_FFFC;

    typedef struct {
        logic [31:0] addr;
        bit          stale;
    } txn_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        stallF;
    logic        pcsrcD;
    logic [31:0] pcbranchD;
    logic [31:0] instrF;
    logic [31:0] pcplus4F;
    logic [31:0] pcF;
    logic        instr_validF;

    logic        stall1;
    logic        pcsrc1;
    logic [31:0] pcbranch1;
    logic [31:0] instrF1;
    logic [31:0] pcplus4F1;
    logic [31:0] pcF1;
    logic        instr_validF1;

    m_fetch_unit_if mem ();
    m_fetch_unit_if mem1 ();

    m_fetch_unit #(.RESET_PC(32'h0), .NOP_INSTR(32'h0)) dut (
        .clk         (clk),
        .reset       (reset),
        .stallF      (stallF),
        .pcsrcD      (pcsrcD),
        .pcbranchD   (pcbranchD),
        .imem        (mem),
        .instrF      (instrF),
        .pcplus4F    (pcplus4F),
        .pcF         (pcF),
        .instr_validF(instr_validF)
    );

    m_fetch_unit #(.RESET_PC(HI_PC), .NOP_INSTR(32'h0)) dut_hi (
        .clk         (clk),
        .reset       (reset),
        .stallF      (stall1),
        .pcsrcD      (pcsrc1),
        .pcbranchD   (pcbranch1),
        .imem        (mem1),
        .instrF      (instrF1),
        .pcplus4F    (pcplus4F1),
        .pcF         (pcF1),
        .instr_validF(instr_validF1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    txn_t        outq[$];
    logic [31:0] m_pc, m_instr, m_pcF, m_pcp4;
    bit          m_valid = 1'b0;
    bit          m_known = 1'b0;

    // Memory environment state
    bit          mem_busy = 1'b0;
    int          mem_cnt  = 0;
    int          mem_lat  = 1;
    logic [31:0] mem_addr = 32'h0;
    bit          spur_en  = 1'b0;
    bit          m1_pend  = 1'b0;
    logic [31:0] m1_addr  = 32'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs at negedge, compare against the model, advance the model, wait.
    task automatic cycle(input bit rst, input bit stall, input bit br,
                         input logic [31:0] tgt, input bit g);
        bit   rv_real;
        bit   req_exp;
        bit   cap;
        txn_t t;

        reset     = rst;
        stallF    = stall;
        pcsrcD    = br;
        pcbranchD = tgt;
        mem.gnt   = g;
        rv_real   = mem_busy && (mem_cnt == 0);
        if (rv_real) begin
            mem.rvalid = 1'b1;
            mem.rdata  = mem_addr ^ K;
        end else if (spur_en && !mem_busy && ($urandom_range(0, 9) == 0)) begin
            mem.rvalid = 1'b1;
            mem.rdata  = $urandom;
        end else begin
            mem.rvalid = 1'b0;
            mem.rdata  = $urandom;
        end
        mem1.gnt    = 1'b1;
        mem1.rvalid = m1_pend;
        mem1.rdata  = m1_addr ^ K;
        #1;

        req_exp = !rst && (outq.size() == 0) && (!m_valid || !stall);
        check("req", 32'(mem.req), 32'(req_exp));
        if (m_known) begin
            check("addr", mem.addr, m_pc);
            check("valid", 32'(instr_validF), 32'(m_valid));
            check("instrF", instrF, m_valid ? m_instr : 32'h0);
            check("pcF", pcF, m_pcF);
            check("pcplus4F", pcplus4F, m_pcp4);
        end

        if (rst) begin
            mem_busy = 1'b0;
            m1_pend  = 1'b0;
        end else begin
            if (rv_real) mem_busy = 1'b0;
            else if (mem_busy) mem_cnt--;
            if (mem.req && g) begin
                mem_busy = 1'b1;
                mem_cnt  = mem_lat - 1;
                mem_addr = mem.addr;
            end
            m1_pend = mem1.req;
            if (mem1.req) m1_addr = mem1.addr;
        end

        if (rst) begin
            outq.delete();
            m_pc    = 32'h0;
            m_valid = 1'b0;
            m_instr = 32'h0;
            m_pcF   = 32'h0;
            m_pcp4  = 32'h0;
            m_known = 1'b1;
        end else begin
            cap = 1'b0;
            if (outq.size() > 0 && mem.rvalid) begin
                t   = outq.pop_front();
                cap = !t.stale && !br;
            end else if (outq.size() > 0 && br) begin
                t       = outq.pop_front();
                t.stale = 1'b1;
                outq.push_front(t);
            end
            if (req_exp && g) outq.push_back('{addr: m_pc, stale: br});
            if (br) begin
                m_valid = 1'b0;
                m_pc    = tgt & ~32'h3;
            end else begin
                if (!stall) m_valid = 1'b0;
                if (cap) begin
                    m_valid = 1'b1;
                    m_instr = t.addr ^ K;
                    m_pcF   = t.addr;
                    m_pcp4  = t.addr + 32'd4;
                    m_pc    = t.addr + 32'd4;
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] tgt;
        reset = 1'b1; stallF = 1'b0; pcsrcD = 1'b0; pcbranchD = 32'h0;
        mem.gnt = 1'b0; mem.rvalid = 1'b0; mem.rdata = 32'h0;
        mem1.gnt = 1'b0; mem1.rvalid = 1'b0; mem1.rdata = 32'h0;
        stall1 = 1'b0; pcsrc1 = 1'b0; pcbranch1 = 32'h0;
        @(negedge clk);

        // Reset, then back-to-back fetches with a zero-wait memory
        cycle(1, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 1);
        check("rst_valid", 32'(instr_validF), 32'h0);
        check("rst_instr", instrF, 32'h0);
        check("rst_pcF", pcF, 32'h0);
        check("rst_pcplus4", pcplus4F, 32'h0);
        check("rst_addr", mem.addr, 32'h0);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        check("t1_valid0", 32'(instr_validF), 32'h1);
        check("t1_instr0", instrF, 32'hA5A5_0000);
        check("t1_pcplus4_0", pcplus4F, 32'h4);
        check("t5_valid", 32'(instr_validF1), 32'h1);
        check("t5_pcF", pcF1, HI_PC);
        check("t5_pcplus4_wrap", pcplus4F1, 32'h0);
        check("t5_addr2", mem1.addr, 32'h0);
        check("t5_req2", 32'(mem1.req), 32'h1);
        cycle(0, 0, 0, 0, 1);
        check("t1_gap", 32'(instr_validF), 32'h0);
        cycle(0, 0, 0, 0, 1);
        check("t1_instr1", instrF, 32'hA5A5_0004);
        check("t1_pcF1", pcF, 32'h4);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        check("t1_instr2", instrF, 32'hA5A5_0008);
        check("t1_pcplus4_2", pcplus4F, 32'hC);

        // Stall with a buffered instruction
        repeat (5) cycle(0, 1, 0, 0, 1);
        check("t2_instr", instrF, 32'hA5A5_0008);
        check("t2_pcF", pcF, 32'h8);
        check("t2_req", 32'(mem.req), 32'h0);
        check("t2_next_addr", mem.addr, 32'hC);

        // Redirect while waiting; response arrives later and is dropped
        mem_lat = 3;
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 1, 32'h0000_0103, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        check("t3_valid", 32'(instr_validF), 32'h0);
        check("t3_instr_nop", instrF, 32'h0);
        check("t3_addr", mem.addr, 32'h0000_0100);

        // Redirect on the grant cycle
        mem_lat = 1;
        cycle(0, 0, 1, 32'h0000_0200, 1);
        cycle(0, 0, 0, 0, 1);
        check("t4_valid", 32'(instr_validF), 32'h0);
        check("t4_addr", mem.addr, 32'h0000_0200);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        check("t4_instr", instrF, 32'hA5A5_0200);
        check("t4_pcF", pcF, 32'h0000_0200);

        // Grant withheld, then reset while waiting
        mem_lat = 5;
        repeat (4) cycle(0, 0, 0, 0, 0);
        check("t6_req_held", 32'(mem.req), 32'h1);
        check("t6_addr_held", mem.addr, 32'h0000_0204);
        cycle(0, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 0);
        check("t6_valid", 32'(instr_validF), 32'h0);
        check("t6_instr", instrF, 32'h0);
        check("t6_pcF", pcF, 32'h0);
        check("t6_pcplus4", pcplus4F, 32'h0);
        check("t6_addr", mem.addr, 32'h0);
        cycle(0, 0, 0, 0, 1);

        // Random traffic: latency, grant, stall, redirect, spurious rvalid, occasional reset
        spur_en = 1'b1;
        for (int i = 0; i < 400; i++) begin
            mem_lat = $urandom_range(1, 3);
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF8 | ($urandom & 32'h3)) : $urandom;
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 9) == 0, tgt, $urandom_range(0, 3) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
